// File: rtl/simio_vga_timing_ctrl.sv
// VGA timing controller for the SimIO VGA sink: mode counters, a 2-stage sync/blank
// pipeline aligned with a 1-cycle-latency pixel source, and underrun/frame tracking.
module simio_vga_timing_ctrl #(
    parameter int   RGB_DEPTH = 2,
    parameter int   H_ACTIVE  = 640,
    parameter int   H_FP      = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BP      = 48,
    parameter int   V_ACTIVE  = 480,
    parameter int   V_FP      = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BP      = 33,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    localparam int  H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW        = $clog2(H_TOTAL),
    localparam int  YW        = $clog2(V_TOTAL)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 clr_i,
    output logic                 req_o,
    output logic [XW-1:0]        x_o,
    output logic [YW-1:0]        y_o,
    input  logic                 pix_valid_i,
    input  logic [RGB_DEPTH-1:0] pix_r_i,
    input  logic [RGB_DEPTH-1:0] pix_g_i,
    input  logic [RGB_DEPTH-1:0] pix_b_i,
    output logic [RGB_DEPTH-1:0] r_o,
    output logic [RGB_DEPTH-1:0] g_o,
    output logic [RGB_DEPTH-1:0] b_o,
    output logic                 hs_o,
    output logic                 vs_o,
    output logic                 de_o,
    output logic                 frame_start_o,
    output logic [15:0]          frame_cnt_o,
    output logic                 underrun_o
);

    localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] H_ACT_L  = XW'(H_ACTIVE);
    localparam logic [XW-1:0] HS_BEG   = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] V_ACT_L  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] VS_BEG   = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [XW-1:0]        h_r;
    logic [XW-1:0]        h_next_s;
    logic [YW-1:0]        v_r;
    logic [YW-1:0]        v_next_s;
    logic                 frame_wrap_s;
    logic                 run_s;
    logic                 active_s;
    logic                 hsync_s;
    logic                 vsync_s;
    logic                 s1_active_r;
    logic                 s1_hsync_r;
    logic                 s1_vsync_r;
    logic                 pix_take_s;
    logic                 de_r;
    logic                 hs_r;
    logic                 vs_r;
    logic [RGB_DEPTH-1:0] r_r;
    logic [RGB_DEPTH-1:0] g_r;
    logic [RGB_DEPTH-1:0] b_r;
    logic                 underrun_r;
    logic                 frame_start_r;
    logic [15:0]          frame_cnt_r;

    // State and raster counter registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            h_r     <= {XW{1'b0}};
            v_r     <= {YW{1'b0}};
        end else begin
            state_r <= state_next_s;
            h_r     <= h_next_s;
            v_r     <= v_next_s;
        end
    end

    // Next-state and counter advance; leaving RUN parks the raster at (0,0)
    always_comb begin
        state_next_s = IDLE;
        h_next_s     = {XW{1'b0}};
        v_next_s     = {YW{1'b0}};
        frame_wrap_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (en_i) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (en_i) begin
                    state_next_s = RUN;
                    if (h_r == H_LAST) begin
                        h_next_s = {XW{1'b0}};
                        if (v_r == V_LAST) begin
                            v_next_s     = {YW{1'b0}};
                            frame_wrap_s = 1'b1;
                        end else begin
                            v_next_s     = v_r + {{(YW-1){1'b0}}, 1'b1};
                            frame_wrap_s = 1'b0;
                        end
                    end else begin
                        h_next_s = h_r + {{(XW-1){1'b0}}, 1'b1};
                        v_next_s = v_r;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Stage-0 decode of the current raster position
    always_comb begin
        run_s      = (state_r == RUN);
        active_s   = (h_r < H_ACT_L) && (v_r < V_ACT_L);
        hsync_s    = (h_r >= HS_BEG) && (h_r < HS_END);
        vsync_s    = (v_r >= VS_BEG) && (v_r < VS_END);
        pix_take_s = s1_active_r && pix_valid_i;
    end

    // Stage 1: timing flags gated by RUN so IDLE drains the pipeline
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_active_r <= 1'b0;
            s1_hsync_r  <= 1'b0;
            s1_vsync_r  <= 1'b0;
        end else begin
            s1_active_r <= run_s && active_s;
            s1_hsync_r  <= run_s && hsync_s;
            s1_vsync_r  <= run_s && vsync_s;
        end
    end

    // Stage 2: display-facing registers; missing source data blanks the pixel
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            de_r <= 1'b0;
            hs_r <= ~HS_POL;
            vs_r <= ~VS_POL;
            r_r  <= {RGB_DEPTH{1'b0}};
            g_r  <= {RGB_DEPTH{1'b0}};
            b_r  <= {RGB_DEPTH{1'b0}};
        end else begin
            de_r <= s1_active_r;
            hs_r <= s1_hsync_r ? HS_POL : ~HS_POL;
            vs_r <= s1_vsync_r ? VS_POL : ~VS_POL;
            if (pix_take_s) begin
                r_r <= pix_r_i;
                g_r <= pix_g_i;
                b_r <= pix_b_i;
            end else begin
                r_r <= {RGB_DEPTH{1'b0}};
                g_r <= {RGB_DEPTH{1'b0}};
                b_r <= {RGB_DEPTH{1'b0}};
            end
        end
    end

    // Sticky underrun flag; a new underrun wins over a same-cycle clear
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_r <= 1'b0;
        end else if (s1_active_r && !pix_valid_i) begin
            underrun_r <= 1'b1;
        end else if (clr_i) begin
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    // Frame start is registered from the next raster position so it lines up with (0,0)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_start_r <= 1'b0;
            frame_cnt_r   <= 16'd0;
        end else begin
            frame_start_r <= (state_next_s == RUN) && (h_next_s == {XW{1'b0}})
                             && (v_next_s == {YW{1'b0}});
            if (frame_wrap_s) begin
                frame_cnt_r <= frame_cnt_r + 16'd1;
            end else begin
                frame_cnt_r <= frame_cnt_r;
            end
        end
    end

    assign req_o         = run_s && active_s;
    assign x_o           = h_r;
    assign y_o           = v_r;
    assign r_o           = r_r;
    assign g_o           = g_r;
    assign b_o           = b_r;
    assign hs_o          = hs_r;
    assign vs_o          = vs_r;
    assign de_o          = de_r;
    assign frame_start_o = frame_start_r;
    assign frame_cnt_o   = frame_cnt_r;
    assign underrun_o    = underrun_r;

endmodule

// File: tb/tb_simio_vga_timing_ctrl.sv
// Directed bench: a default 640x480 instance (a) and a tiny 8x6-total instance (b),
// each fed by a 1-cycle-latency pattern source r=x[1:0], g=y[1:0], b=3.
module tb_simio_vga_timing_ctrl;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic       en_a, clr_a, pix_valid_a, req_a, hs_a, vs_a, de_a, fs_a, ur_a;
    logic [9:0] x_a;
    logic [9:0] y_a;
    logic [1:0] pix_r_a, pix_g_a, pix_b_a, r_a, g_a, b_a;
    logic [15:0] fc_a;

    logic       en_b, clr_b, pix_valid_b, req_b, hs_b, vs_b, de_b, fs_b, ur_b;
    logic [2:0] x_b;
    logic [2:0] y_b;
    logic [1:0] pix_r_b, pix_g_b, pix_b_b, r_b, g_b, b_b;
    logic [15:0] fc_b;

    logic       pend_valid_a, pend_valid_b, drop_on_b;
    logic [1:0] pend_r_a, pend_g_a, pend_r_b, pend_g_b;

    int vs_low_cnt, vs_first, fs_cnt, de_cnt_b;
    int de_cnt_a, hs_cnt_a, hs_fall_a, rise_a1, rise_a2, fall_a;
    logic de_prev;

    simio_vga_timing_ctrl dut_a (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_a), .clr_i(clr_a),
        .req_o(req_a), .x_o(x_a), .y_o(y_a), .pix_valid_i(pix_valid_a),
        .pix_r_i(pix_r_a), .pix_g_i(pix_g_a), .pix_b_i(pix_b_a),
        .r_o(r_a), .g_o(g_a), .b_o(b_a), .hs_o(hs_a), .vs_o(vs_a), .de_o(de_a),
        .frame_start_o(fs_a), .frame_cnt_o(fc_a), .underrun_o(ur_a)
    );

    simio_vga_timing_ctrl #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en_b), .clr_i(clr_b),
        .req_o(req_b), .x_o(x_b), .y_o(y_b), .pix_valid_i(pix_valid_b),
        .pix_r_i(pix_r_b), .pix_g_i(pix_g_b), .pix_b_i(pix_b_b),
        .r_o(r_b), .g_o(g_b), .b_o(b_b), .hs_o(hs_b), .vs_o(vs_b), .de_o(de_b),
        .frame_start_o(fs_b), .frame_cnt_o(fc_b), .underrun_o(ur_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle; present the response to last cycle's request, then latch this cycle's.
    task automatic tick();
        @(posedge clk);
        #1;
        pix_valid_a = pend_valid_a;
        pix_r_a     = pend_r_a;
        pix_g_a     = pend_g_a;
        pix_b_a     = 2'd3;
        pix_valid_b = pend_valid_b;
        pix_r_b     = pend_r_b;
        pix_g_b     = pend_g_b;
        pix_b_b     = 2'd3;
        pend_valid_a = req_a;
        pend_r_a     = x_a[1:0];
        pend_g_a     = y_a[1:0];
        pend_valid_b = req_b && !(drop_on_b && (((x_b == 3'd2) && (y_b == 3'd0)) ||
                                                ((x_b == 3'd1) && (y_b == 3'd2))));
        pend_r_b     = x_b[1:0];
        pend_g_b     = y_b[1:0];
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
        pix_valid_a = 1'b0; pix_r_a = 2'd0; pix_g_a = 2'd0; pix_b_a = 2'd0;
        pix_valid_b = 1'b0; pix_r_b = 2'd0; pix_g_b = 2'd0; pix_b_b = 2'd0;
        pend_valid_a = 1'b0; pend_r_a = 2'd0; pend_g_a = 2'd0;
        pend_valid_b = 1'b0; pend_r_b = 2'd0; pend_g_b = 2'd0;
        drop_on_b = 1'b1;
        vs_low_cnt = 0; vs_first = 0; fs_cnt = 0; de_cnt_b = 0;
        de_cnt_a = 0; hs_cnt_a = 0; hs_fall_a = 0; rise_a1 = 0; rise_a2 = 0; fall_a = 0;
        de_prev = 1'b0;

        // Reset held with enable high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_r", {30'd0, r_a}, 32'd0);
        chk("rst_g", {30'd0, g_a}, 32'd0);
        chk("rst_b", {30'd0, b_a}, 32'd0);
        chk("rst_de", {31'd0, de_a}, 32'd0);
        chk("rst_req", {31'd0, req_a}, 32'd0);
        chk("rst_x", {22'd0, x_a}, 32'd0);
        chk("rst_y", {22'd0, y_a}, 32'd0);
        chk("rst_hs", {31'd0, hs_a}, 32'd1);
        chk("rst_vs", {31'd0, vs_a}, 32'd1);
        chk("rst_fs", {31'd0, fs_a}, 32'd0);
        chk("rst_fc", {16'd0, fc_a}, 32'd0);
        chk("rst_ur", {31'd0, ur_a}, 32'd0);
        chk("rst_b_hs", {31'd0, hs_b}, 32'd1);
        chk("rst_b_vs", {31'd0, vs_b}, 32'd1);
        en_a  = 1'b0;
        rst_n = 1'b1;

        // Small mode: cycle n has stage-0 index n-1 and stage-2 index n-3
        for (int n = 1; n <= 96; n++) begin
            tick();
            if (n <= 48 && !vs_b) begin
                vs_low_cnt++;
                if (vs_first == 0) vs_first = n;
            end
            if (n <= 48 && de_b) de_cnt_b++;
            if (fs_b) fs_cnt++;
            case (n)
                1: begin
                    chk("b1_req", {31'd0, req_b}, 32'd1);
                    chk("b1_x", {29'd0, x_b}, 32'd0);
                    chk("b1_y", {29'd0, y_b}, 32'd0);
                    chk("b1_fs", {31'd0, fs_b}, 32'd1);
                    chk("b1_de", {31'd0, de_b}, 32'd0);
                    chk("a_idle_req", {31'd0, req_a}, 32'd0);
                end
                2: chk("b2_fs", {31'd0, fs_b}, 32'd0);
                3: begin
                    chk("b3_de", {31'd0, de_b}, 32'd1);
                    chk("b3_r", {30'd0, r_b}, 32'd0);
                    chk("b3_b", {30'd0, b_b}, 32'd3);
                end
                4: chk("b4_ur", {31'd0, ur_b}, 32'd0);
                5: begin
                    chk("b5_de", {31'd0, de_b}, 32'd1);
                    chk("b5_r_underrun", {30'd0, r_b}, 32'd0);
                    chk("b5_b_underrun", {30'd0, b_b}, 32'd0);
                    chk("b5_ur", {31'd0, ur_b}, 32'd1);
                    chk("b5_req_h4", {31'd0, req_b}, 32'd0);
                    chk("b5_x", {29'd0, x_b}, 32'd4);
                end
                6: begin
                    chk("b6_r", {30'd0, r_b}, 32'd3);
                    chk("b6_b", {30'd0, b_b}, 32'd3);
                    chk("b6_ur", {31'd0, ur_b}, 32'd1);
                end
                7: begin
                    chk("b7_de", {31'd0, de_b}, 32'd0);
                    chk("b7_b", {30'd0, b_b}, 32'd0);
                end
                8: chk("b8_hs", {31'd0, hs_b}, 32'd0);
                9: chk("b9_hs", {31'd0, hs_b}, 32'd0);
                10: chk("b10_hs", {31'd0, hs_b}, 32'd1);
                11: begin
                    chk("b11_r", {30'd0, r_b}, 32'd0);
                    chk("b11_g", {30'd0, g_b}, 32'd1);
                end
                12: begin
                    chk("b12_r", {30'd0, r_b}, 32'd1);
                    chk("b12_g", {30'd0, g_b}, 32'd1);
                end
                19: clr_b = 1'b1;
                20: begin
                    chk("b20_ur_set_wins", {31'd0, ur_b}, 32'd1);
                    chk("b20_g_underrun", {30'd0, g_b}, 32'd0);
                    chk("b20_de", {31'd0, de_b}, 32'd1);
                    clr_b = 1'b0;
                end
                21: clr_b = 1'b1;
                22: begin
                    chk("b22_ur_clr", {31'd0, ur_b}, 32'd0);
                    chk("b22_r", {30'd0, r_b}, 32'd3);
                    chk("b22_g", {30'd0, g_b}, 32'd2);
                    clr_b = 1'b0;
                end
                23: chk("b23_ur", {31'd0, ur_b}, 32'd0);
                25: begin
                    chk("b25_req", {31'd0, req_b}, 32'd0);
                    chk("b25_y", {29'd0, y_b}, 32'd3);
                end
                30: drop_on_b = 1'b0;
                48: begin
                    chk("b48_fc", {16'd0, fc_b}, 32'd0);
                    chk("b48_fs", {31'd0, fs_b}, 32'd0);
                end
                49: begin
                    chk("b49_fc", {16'd0, fc_b}, 32'd1);
                    chk("b49_fs", {31'd0, fs_b}, 32'd1);
                    chk("b49_x", {29'd0, x_b}, 32'd0);
                    chk("b49_y", {29'd0, y_b}, 32'd0);
                end
                96: begin
                    en_b = 1'b0;
                    en_a = 1'b1;
                end
                default: ;
            endcase
        end
        chk("b_vs_low_cycles", vs_low_cnt, 32'd8);
        chk("b_vs_first", vs_first, 32'd35);
        chk("b_fs_count", fs_cnt, 32'd2);
        chk("b_de_count", de_cnt_b, 32'd12);
        chk("b_ur_end", {31'd0, ur_b}, 32'd0);

        // Default mode: lines, data path, mid-frame stop at (100,5) and restart
        for (int k = 1; k <= 4105; k++) begin
            tick();
            if (de_a && !de_prev) begin
                if (rise_a1 == 0) rise_a1 = k;
                else if (rise_a2 == 0) rise_a2 = k;
            end
            if (!de_a && de_prev && fall_a == 0) fall_a = k;
            if (k <= 800 && de_a) de_cnt_a++;
            if (k <= 800 && !hs_a) hs_cnt_a++;
            if (!hs_a && hs_fall_a == 0) hs_fall_a = k;
            de_prev = de_a;
            case (k)
                1: begin
                    chk("a1_req", {31'd0, req_a}, 32'd1);
                    chk("a1_fs", {31'd0, fs_a}, 32'd1);
                    chk("a1_x", {22'd0, x_a}, 32'd0);
                end
                3: begin
                    chk("a3_r", {30'd0, r_a}, 32'd0);
                    chk("a3_b", {30'd0, b_a}, 32'd3);
                end
                104: chk("a104_r", {30'd0, r_a}, 32'd1);
                1603: begin
                    chk("a1603_de", {31'd0, de_a}, 32'd1);
                    chk("a1603_g", {30'd0, g_a}, 32'd2);
                end
                4101: begin
                    chk("a_stop_x", {22'd0, x_a}, 32'd100);
                    chk("a_stop_y", {22'd0, y_a}, 32'd5);
                    chk("a_stop_req", {31'd0, req_a}, 32'd1);
                    chk("a_stop_vs", {31'd0, vs_a}, 32'd1);
                    en_a = 1'b0;
                end
                4102: begin
                    chk("a_idle_req", {31'd0, req_a}, 32'd0);
                    chk("a_idle_x", {22'd0, x_a}, 32'd0);
                    chk("a_idle_y", {22'd0, y_a}, 32'd0);
                end
                4104: begin
                    chk("a_flush_de", {31'd0, de_a}, 32'd0);
                    chk("a_flush_hs", {31'd0, hs_a}, 32'd1);
                    chk("a_flush_vs", {31'd0, vs_a}, 32'd1);
                    chk("a_flush_r", {30'd0, r_a}, 32'd0);
                    chk("a_flush_fs", {31'd0, fs_a}, 32'd0);
                    en_a = 1'b1;
                end
                4105: begin
                    chk("a_restart_fs", {31'd0, fs_a}, 32'd1);
                    chk("a_restart_req", {31'd0, req_a}, 32'd1);
                    chk("a_restart_x", {22'd0, x_a}, 32'd0);
                    chk("a_restart_y", {22'd0, y_a}, 32'd0);
                    chk("a_fc", {16'd0, fc_a}, 32'd0);
                    chk("a_ur", {31'd0, ur_a}, 32'd0);
                end
                default: ;
            endcase
        end
        chk("a_de_rise", rise_a1, 32'd3);
        chk("a_de_fall", fall_a, 32'd643);
        chk("a_de_count", de_cnt_a, 32'd640);
        chk("a_line_period", rise_a2 - rise_a1, 32'd800);
        chk("a_hs_offset", hs_fall_a - rise_a1, 32'd656);
        chk("a_hs_width", hs_cnt_a, 32'd96);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
